alu_control_unit: RTL and testbench

ALU_CONTROL_UNIT -- requirements
Module: alu_control_unit

---
 rtl/alu_control_unit.sv | 184 ++++++++++++++++++
 tb/tb_alu_control_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/alu_control_unit.sv
// MIPS single-cycle style control decode, ALU control and ALU, with every output
// registered one cycle after the instruction and operands are sampled.
module alu_control_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [31:0]      instr,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic             out_valid,
    output logic             regdst,
    output logic             branch_eq,
    output logic             branch_ne,
    output logic             memread,
    output logic             memwrite,
    output logic             memtoreg,
    output logic             regwrite,
    output logic             alusrc,
    output logic             jump,
    output logic [1:0]       aluop,
    output logic [5:0]       aluctl,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    localparam int unsigned OP_W   = 6;
    localparam int unsigned CTL_W  = 6;
    localparam int unsigned IMM_W  = 16;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    localparam logic [CTL_W-1:0] CTL_AND = 6'd0;
    localparam logic [CTL_W-1:0] CTL_OR  = 6'd1;
    localparam logic [CTL_W-1:0] CTL_ADD = 6'd2;
    localparam logic [CTL_W-1:0] CTL_SUB = 6'd6;
    localparam logic [CTL_W-1:0] CTL_SLT = 6'd7;
    localparam logic [CTL_W-1:0] CTL_NOR = 6'd12;
    localparam logic [CTL_W-1:0] CTL_XOR = 6'd13;

    logic [OP_W-1:0]  opcode_c;
    logic [5:0]       funct_c;
    logic [IMM_W-1:0] imm_c;
    logic             unused_instr_bits;

    logic             regdst_c, branch_eq_c, branch_ne_c, memread_c, memwrite_c;
    logic             memtoreg_c, regwrite_c, alusrc_c, jump_c;
    logic [1:0]       aluop_c;
    logic [CTL_W-1:0] aluctl_c;
    logic [WIDTH-1:0] b_c;
    logic [WIDTH-1:0] result_c;

    assign opcode_c          = instr[31:26];
    assign funct_c           = instr[5:0];
    assign imm_c             = instr[15:0];
    assign unused_instr_bits = ^instr[25:16];

    // Main control decode; unknown opcodes fall through as a NOP.
    always_comb begin
        regdst_c    = 1'b0;
        branch_eq_c = 1'b0;
        branch_ne_c = 1'b0;
        memread_c   = 1'b0;
        memwrite_c  = 1'b0;
        memtoreg_c  = 1'b0;
        regwrite_c  = 1'b0;
        alusrc_c    = 1'b0;
        jump_c      = 1'b0;
        aluop_c     = 2'b00;
        case (opcode_c)
            OP_RTYPE: begin
                regdst_c   = 1'b1;
                regwrite_c = 1'b1;
                aluop_c    = 2'b10;
            end
            OP_LW: begin
                memread_c  = 1'b1;
                memtoreg_c = 1'b1;
                alusrc_c   = 1'b1;
                regwrite_c = 1'b1;
            end
            OP_SW: begin
                memwrite_c = 1'b1;
                alusrc_c   = 1'b1;
            end
            OP_BEQ: begin
                branch_eq_c = 1'b1;
                aluop_c     = 2'b01;
            end
            OP_BNE: begin
                branch_ne_c = 1'b1;
                aluop_c     = 2'b01;
            end
            OP_ADDI: begin
                alusrc_c   = 1'b1;
                regwrite_c = 1'b1;
            end
            OP_J: jump_c = 1'b1;
            default: ;
        endcase
    end

    // ALU control from operation class and funct field.
    always_comb begin
        aluctl_c = CTL_AND;
        case (aluop_c)
            2'b00: aluctl_c = CTL_ADD;
            2'b01: aluctl_c = CTL_SUB;
            2'b10: begin
                case (funct_c)
                    6'b100000: aluctl_c = CTL_ADD;
                    6'b100010: aluctl_c = CTL_SUB;
                    6'b100100: aluctl_c = CTL_AND;
                    6'b100101: aluctl_c = CTL_OR;
                    6'b100110: aluctl_c = CTL_XOR;
                    6'b100111: aluctl_c = CTL_NOR;
                    6'b101010: aluctl_c = CTL_SLT;
                    default:   aluctl_c = CTL_AND;
                endcase
            end
            default: aluctl_c = CTL_AND;
        endcase
    end

    assign b_c = alusrc_c ? {{(WIDTH-IMM_W){imm_c[IMM_W-1]}}, imm_c} : rt_data;

    // Datapath; add/sub wrap naturally at WIDTH bits.
    always_comb begin
        result_c = '0;
        case (aluctl_c)
            CTL_AND: result_c = rs_data & b_c;
            CTL_OR:  result_c = rs_data | b_c;
            CTL_ADD: result_c = rs_data + b_c;
            CTL_SUB: result_c = rs_data - b_c;
            CTL_SLT: result_c = WIDTH'($signed(rs_data) < $signed(b_c));
            CTL_NOR: result_c = ~(rs_data | b_c);
            CTL_XOR: result_c = rs_data ^ b_c;
            default: result_c = '0;
        endcase
    end

    // Output register; reset leaves zero=1 to stay consistent with result=0.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid <= 1'b0;
            regdst    <= 1'b0;
            branch_eq <= 1'b0;
            branch_ne <= 1'b0;
            memread   <= 1'b0;
            memwrite  <= 1'b0;
            memtoreg  <= 1'b0;
            regwrite  <= 1'b0;
            alusrc    <= 1'b0;
            jump      <= 1'b0;
            aluop     <= 2'b00;
            aluctl    <= '0;
            result    <= '0;
            zero      <= 1'b1;
        end else begin
            out_valid <= in_valid;
            regdst    <= regdst_c;
            branch_eq <= branch_eq_c;
            branch_ne <= branch_ne_c;
            memread   <= memread_c;
            memwrite  <= memwrite_c;
            memtoreg  <= memtoreg_c;
            regwrite  <= regwrite_c;
            alusrc    <= alusrc_c;
            jump      <= jump_c;
            aluop     <= aluop_c;
            aluctl    <= aluctl_c;
            result    <= result_c;
            zero      <= (result_c == '0);
        end
    end

endmodule

// File: tb/tb_alu_control_unit.sv
// Directed and randomized checks of alu_control_unit against a table-driven
// behavioural model of the MIPS decode and ALU rules.
module tb_alu_control_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] instr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        out_valid, regdst, branch_eq, branch_ne, memread, memwrite;
    logic        memtoreg, regwrite, alusrc, jump, zero;
    logic [1:0]  aluop;
    logic [5:0]  aluctl;
    logic [31:0] result;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    alu_control_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .instr(instr),
        .rs_data(rs_data), .rt_data(rt_data), .out_valid(out_valid),
        .regdst(regdst), .branch_eq(branch_eq), .branch_ne(branch_ne),
        .memread(memread), .memwrite(memwrite), .memtoreg(memtoreg),
        .regwrite(regwrite), .alusrc(alusrc), .jump(jump), .aluop(aluop),
        .aluctl(aluctl), .result(result), .zero(zero)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Flag order: {regdst, branch_eq, branch_ne, memread, memwrite, memtoreg, regwrite, alusrc, jump}
    function automatic logic [8:0] flags_for(input logic [5:0] op);
        case (op)
            6'b000000: return 9'b1_0_0_0_0_0_1_0_0;
            6'b100011: return 9'b0_0_0_1_0_1_1_1_0;
            6'b101011: return 9'b0_0_0_0_1_0_0_1_0;
            6'b000100: return 9'b0_1_0_0_0_0_0_0_0;
            6'b000101: return 9'b0_0_1_0_0_0_0_0_0;
            6'b001000: return 9'b0_0_0_0_0_0_1_1_0;
            6'b000010: return 9'b0_0_0_0_0_0_0_0_1;
            default:   return 9'b0;
        endcase
    endfunction

    function automatic logic [1:0] aluop_for(input logic [5:0] op);
        if (op == 6'b000000) return 2'b10;
        if (op == 6'b000100 || op == 6'b000101) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [5:0] ctl_for(input logic [1:0] aop, input logic [5:0] fn);
        if (aop == 2'b00) return 6'd2;
        if (aop == 2'b01) return 6'd6;
        if (aop == 2'b11) return 6'd0;
        case (fn)
            6'b100000: return 6'd2;
            6'b100010: return 6'd6;
            6'b100101: return 6'd1;
            6'b100110: return 6'd13;
            6'b100111: return 6'd12;
            6'b101010: return 6'd7;
            default:   return 6'd0;
        endcase
    endfunction

    // Plain integer arithmetic on 64-bit values, truncated to 32 bits.
    function automatic logic [31:0] alu_ref(input logic [5:0] ctl, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        case (ctl)
            6'd0:  return a & b;
            6'd1:  return a | b;
            6'd2:  return 32'((ua + ub) % 64'h1_0000_0000);
            6'd6:  return 32'((ua + 64'h1_0000_0000 - ub) % 64'h1_0000_0000);
            6'd7:  return (sa < sb) ? 32'd1 : 32'd0;
            6'd12: return 32'hFFFF_FFFF ^ (a | b);
            6'd13: return a ^ b;
            default: return 32'd0;
        endcase
    endfunction

    // Drive one cycle of inputs, then compare the registered outputs with the model.
    task automatic apply(input logic rst_lvl, input logic vld, input logic [31:0] ins,
                         input logic [31:0] a, input logic [31:0] rt);
        logic [8:0]  ef;
        logic [1:0]  eop;
        logic [5:0]  ectl;
        logic [31:0] eb, eres;
        logic        ev;
        @(negedge clk);
        reset = rst_lvl; in_valid = vld; instr = ins; rs_data = a; rt_data = rt;
        @(posedge clk);
        #1;
        if (!rst_lvl) begin
            ef = '0; eop = 2'b00; ectl = 6'd0; eres = 32'd0; ev = 1'b0;
        end else begin
            ef   = flags_for(ins[31:26]);
            eop  = aluop_for(ins[31:26]);
            ectl = ctl_for(eop, ins[5:0]);
            eb   = ef[1] ? {{16{ins[15]}}, ins[15:0]} : rt;
            eres = alu_ref(ectl, a, eb);
            ev   = vld;
        end
        check("out_valid", 32'(out_valid), 32'(ev));
        check("flags", 32'({regdst, branch_eq, branch_ne, memread, memwrite, memtoreg,
                            regwrite, alusrc, jump}), 32'(ef));
        check("aluop", 32'(aluop), 32'(eop));
        check("aluctl", 32'(aluctl), 32'(ectl));
        check("result", result, eres);
        check("zero", 32'(zero), (eres == 32'd0) ? 32'd1 : 32'd0);
    endtask

    function automatic logic [31:0] rtype(input logic [5:0] fn);
        return {6'b000000, 20'h12345, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [15:0] imm);
        return {op, 10'h0A5, imm};
    endfunction

    localparam int unsigned N_RAND = 400;

    initial begin
        logic [5:0]  ops [8];
        logic [5:0]  fns [8];
        logic [5:0]  op, fn;
        logic [31:0] ins, a, b;
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b001000,
                6'b000010, 6'b111111};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b100111,
                6'b101010, 6'b000011};
        reset = 1'b0; in_valid = 1'b0; instr = '0; rs_data = '0; rt_data = '0;

        apply(1'b0, 1'b1, rtype(6'b100000), 32'd5, 32'd7);
        apply(1'b0, 1'b1, rtype(6'b100000), 32'd5, 32'd7);

        apply(1'b1, 1'b1, rtype(6'b100000), 32'd5, 32'd7);
        check("add5_7_result", result, 32'd12);
        apply(1'b1, 1'b1, itype(6'b000100, 16'h0000), 32'h1234, 32'h1234);
        check("beq_zero", 32'(zero), 32'd1);
        apply(1'b1, 1'b1, itype(6'b000101, 16'h0000), 32'h1234, 32'h1235);
        check("bne_result", result, 32'hFFFF_FFFF);
        apply(1'b1, 1'b1, itype(6'b100011, 16'hFFFC), 32'h100, 32'hDEAD);
        check("lw_result", result, 32'h0000_00FC);
        apply(1'b1, 1'b1, rtype(6'b101010), 32'hFFFF_FFFF, 32'd1);
        check("slt_result", result, 32'd1);
        apply(1'b1, 1'b1, rtype(6'b100111), 32'd0, 32'd0);
        check("nor_result", result, 32'hFFFF_FFFF);
        apply(1'b1, 1'b1, rtype(6'b100000), 32'hFFFF_FFFF, 32'd1);
        check("addwrap_zero", 32'(zero), 32'd1);
        apply(1'b1, 1'b1, itype(6'b111111, 16'h8000), 32'd3, 32'd4);
        check("unknown_aluctl", 32'(aluctl), 32'd2);
        apply(1'b1, 1'b0, rtype(6'b100110), 32'hF0F0_0000, 32'h0FF0_0000);
        apply(1'b0, 1'b1, rtype(6'b100000), 32'd9, 32'd9);
        apply(1'b1, 1'b1, itype(6'b001000, 16'h8001), 32'h7FFF_FFFF, 32'd0);

        for (int i = 0; i < int'(N_RAND); i++) begin
            op = ops[$urandom_range(0, 7)];
            if ($urandom_range(0, 9) == 0) op = 6'($urandom);
            fn = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fns[$urandom_range(0, 7)];
            ins = {op, 20'($urandom), fn};
            a = $urandom;
            b = ($urandom_range(0, 5) == 0) ? a : $urandom;
            apply(($urandom_range(0, 19) != 0), ($urandom_range(0, 3) != 0), ins, a, b);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
